// File: rtl/serial_reg_master.sv
`default_nettype none
// ============================================================================
// Module   : serial_reg_master
// Brief    : Serialises register read/write commands into strobe/din frames
//            for the serial register slave and collects read data from dout.
// Revision : 1.0 - initial release
// ============================================================================
module serial_reg_master #(
    parameter int ADDR_WIDTH    = 5,
    parameter int REG_WIDTH     = 8,
    parameter int GAP_CYCLES    = 5,
    parameter int RD_SAMPLE_DLY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [REG_WIDTH-1:0]  cmd_wdata,
    output logic                  rsp_valid,
    output logic [REG_WIDTH-1:0]  rsp_rdata,
    output logic                  busy,
    output logic                  strobe,
    output logic                  wr_en,
    output logic                  din,
    input  logic                  dout
);

    localparam int c_FRAME_LEN = ADDR_WIDTH + REG_WIDTH;
    localparam int c_POS_W     = $clog2(c_FRAME_LEN + RD_SAMPLE_DLY);

    localparam logic [c_POS_W-1:0] c_POS_LAST   = c_POS_W'(c_FRAME_LEN - 1);
    localparam logic [c_POS_W-1:0] c_DRAIN_LAST = c_POS_W'(c_FRAME_LEN - 1 + RD_SAMPLE_DLY);
    localparam logic [c_POS_W-1:0] c_CAP_FIRST  = c_POS_W'(ADDR_WIDTH + RD_SAMPLE_DLY);
    localparam logic [c_POS_W-1:0] c_POS_ONE    = c_POS_W'(1);
    localparam logic [3:0]         c_GAP_LAST   = 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GAP    = 3'd1,
        S_STROBE = 3'd2,
        S_SHIFT  = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_gap_cnt;
    logic [c_POS_W-1:0]     r_pos;
    logic [c_FRAME_LEN-1:0] r_frame;
    logic [REG_WIDTH-1:0]   r_cap;
    logic                   r_write;
    logic                   r_cmd_ready;
    logic                   r_rsp_valid;
    logic [REG_WIDTH-1:0]   r_rsp_rdata;
    logic                   r_busy;
    logic                   r_strobe;
    logic                   r_wr_en;
    logic                   r_din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gap_cnt   <= '0;
            r_pos       <= '0;
            r_frame     <= '0;
            r_cap       <= '0;
            r_write     <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_busy      <= 1'b0;
            r_strobe    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_din       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_write     <= cmd_write;
                        r_wr_en     <= cmd_write;
                        // Read frames carry only the address; the data slots stay low.
                        r_frame     <= cmd_write ? {cmd_addr, cmd_wdata}
                                                 : {{REG_WIDTH{1'b0}}, cmd_addr};
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_gap_cnt   <= '0;
                        r_state     <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_strobe <= 1'b1;
                        r_state  <= S_STROBE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                S_STROBE: begin
                    r_strobe <= 1'b0;
                    r_din    <= r_frame[0];
                    r_frame  <= r_frame >> 1;
                    r_pos    <= '0;
                    r_cap    <= '0;
                    r_state  <= S_SHIFT;
                end
                S_SHIFT, S_DRAIN: begin
                    // r_pos keeps counting through the drain so capture k lands at k + delay.
                    if (!r_write && r_pos >= c_CAP_FIRST) begin
                        r_cap <= {dout, r_cap[REG_WIDTH-1:1]};
                    end
                    if (r_pos == c_DRAIN_LAST) begin
                        r_din       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_write ? '0 : {dout, r_cap[REG_WIDTH-1:1]};
                        r_state     <= S_DONE;
                    end else begin
                        r_pos <= r_pos + c_POS_ONE;
                        if (r_pos == c_POS_LAST) begin
                            r_din   <= 1'b0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_din   <= r_frame[0];
                            r_frame <= r_frame >> 1;
                        end
                    end
                end
                S_DONE: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = r_busy;
    assign strobe    = r_strobe;
    assign wr_en     = r_wr_en;
    assign din       = r_din;

endmodule

`default_nettype wire

// File: tb/tb_serial_reg_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_reg_master
// Brief    : Self-checking bench for serial_reg_master with a behavioural
//            serial slave and a reference register array.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_reg_master;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [4:0] cmd_addr  = '0;
    logic [7:0] cmd_wdata = '0;
    logic       dout = 1'b0;
    logic       cmd_ready, rsp_valid, busy, strobe, wr_en, din;
    logic [7:0] rsp_rdata;

    int n_cmp = 0;
    int n_mis = 0;

    serial_reg_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .strobe    (strobe),
        .wr_en     (wr_en),
        .din       (din),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    // Reference register contents and the slave's own storage
    logic [7:0]  ref_mem [32];
    logic [7:0]  sl_mem  [32];
    logic [13:0] frame_q [$];

    int ncyc = 0, proto_err = 0, strobe_cnt = 0, strobe_cyc = 0, rsp_cnt = 0;

    always @(negedge clk) begin
        ncyc++;
        if (busy === 1'b1 && cmd_ready === 1'b1) proto_err++;
        if (rsp_valid === 1'b1 && busy !== 1'b1) proto_err++;
        if (strobe === 1'b1) begin
            strobe_cnt++;
            strobe_cyc = ncyc;
        end
        if (rsp_valid === 1'b1) rsp_cnt++;
    end

    // Slave: records each frame's din slots, drives read data on dout, noise elsewhere
    int          sl_slot = -1;
    logic        sl_wr = 1'b0;
    logic [12:0] sl_bits = '0;

    always @(negedge clk) begin
        if (rst) begin
            sl_slot = -1;
            dout    = 1'b0;
        end else if (strobe === 1'b1) begin
            sl_slot = 0;
            sl_wr   = wr_en;
            sl_bits = '0;
            dout    = 1'($urandom);
        end else if (sl_slot >= 0) begin
            sl_bits[sl_slot] = din;
            if (!sl_wr && sl_slot >= 5) dout = sl_mem[sl_bits[4:0]][sl_slot-5];
            else                        dout = 1'($urandom);
            if (sl_slot == 12) begin
                if (sl_wr) sl_mem[sl_bits[12:8]] = sl_bits[7:0];
                frame_q.push_back({sl_wr, sl_bits});
                sl_slot = -1;
            end else begin
                sl_slot++;
            end
        end else begin
            dout = 1'($urandom);
        end
    end

    // Issues one command and waits for its response; latency counts from the handshake cycle
    task automatic do_cmd(input string tag, input logic wr, input logic [4:0] addr,
                          input logic [7:0] wdata, output logic [7:0] rdata,
                          output int lat, output int acc);
        int n;
        rdata = 'x; lat = -1; acc = -1;
        @(posedge clk); #1;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (cmd_ready !== 1'b1 && n < 100);
        if (cmd_ready !== 1'b1) begin
            n_cmp++; n_mis++;
            $display("FAIL %s_handshake: cmd_ready=%b required 1 within 100 cycles", tag, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        acc = ncyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 5'($urandom); cmd_wdata = 8'($urandom);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (rsp_valid !== 1'b1 && n < 60);
        if (rsp_valid !== 1'b1) begin
            n_cmp++; n_mis++;
            $display("FAIL %s_rsp_timeout: rsp_valid=%b required 1 within 60 cycles", tag, rsp_valid);
            return;
        end
        lat = ncyc - acc;
        rdata = rsp_rdata;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({strobe, wr_en, din, cmd_ready, rsp_valid, busy, rsp_rdata} !== {6'b000100, 8'h00}) begin
            n_mis++;
            $display("FAIL reset_async: {strobe,wr_en,din,ready,rsp_valid,busy,rdata}=%b required %b",
                     {strobe, wr_en, din, cmd_ready, rsp_valid, busy, rsp_rdata}, {6'b000100, 8'h00});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({cmd_ready, busy} !== 2'b10) begin
            n_mis++;
            $display("FAIL reset_release: {ready,busy}=%b required 10", {cmd_ready, busy});
        end
        proto_err = 0;
    endtask

    task automatic test_write();
        logic [7:0] rd; int lat, acc, sb;
        sb = strobe_cnt;
        ref_mem[1] = 8'h2B;
        do_cmd("write", 1'b1, 5'h01, 8'h2B, rd, lat, acc);
        n_cmp++;
        if (frame_q.size() == 0 || frame_q[$] !== 14'h212B) begin
            n_mis++;
            $display("FAIL write_frame: {wr_en,slots}=%h required 212b", frame_q.size() ? frame_q[$] : 14'h0);
        end
        n_cmp++;
        if (lat != 20) begin n_mis++; $display("FAIL write_latency: got %0d required 20", lat); end
        n_cmp++;
        if (rd !== 8'h00) begin n_mis++; $display("FAIL write_rdata: got %h required 00", rd); end
        n_cmp++;
        if (strobe_cnt - sb != 1 || strobe_cyc - acc != 6) begin
            n_mis++;
            $display("FAIL write_strobe: pulses=%0d offset=%0d required 1 and 6", strobe_cnt - sb, strobe_cyc - acc);
        end
        repeat (2) @(negedge clk); #1;
        n_cmp++;
        if (wr_en !== 1'b1) begin n_mis++; $display("FAIL write_wr_en_hold: got %b required 1", wr_en); end
    endtask

    task automatic test_read();
        logic [7:0] rd; int lat, acc;
        sl_mem[7] = 8'h7C; ref_mem[7] = 8'h7C;
        do_cmd("read", 1'b0, 5'h07, 8'hFF, rd, lat, acc);
        n_cmp++;
        if (frame_q.size() == 0 || frame_q[$] !== 14'h0007) begin
            n_mis++;
            $display("FAIL read_frame: {wr_en,slots}=%h required 0007", frame_q.size() ? frame_q[$] : 14'h0);
        end
        n_cmp++;
        if (rd !== 8'h7C) begin n_mis++; $display("FAIL read_rdata: got %h required 7c", rd); end
        n_cmp++;
        if (lat != 20) begin n_mis++; $display("FAIL read_latency: got %0d required 20", lat); end
        repeat (3) @(negedge clk); #1;
        n_cmp++;
        if (rsp_rdata !== 8'h7C || rsp_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL read_hold: rdata=%h rsp_valid=%b required 7c and 0", rsp_rdata, rsp_valid);
        end
    endtask

    task automatic test_readback_all();
        logic [7:0] rd, wd; int lat, acc;
        for (int a = 0; a <= 16; a++) begin
            wd = 8'($urandom);
            ref_mem[a] = wd;
            do_cmd("rb_write", 1'b1, 5'(a), wd, rd, lat, acc);
            n_cmp++;
            if (rd !== 8'h00 || lat != 20) begin
                n_mis++;
                $display("FAIL rb_write[%0d]: rdata=%h lat=%0d required 00 and 20", a, rd, lat);
            end
        end
        for (int a = 0; a <= 16; a++) begin
            do_cmd("rb_read", 1'b0, 5'(a), 8'($urandom), rd, lat, acc);
            n_cmp++;
            if (rd !== ref_mem[a]) begin
                n_mis++;
                $display("FAIL rb_read[%0d]: got %h required %h", a, rd, ref_mem[a]);
            end
        end
        n_cmp++;
        if (proto_err != 0) begin n_mis++; $display("FAIL rb_protocol: violations=%0d required 0", proto_err); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] wd, rd; int n, acc1, acc2, rb;
        wd = 8'($urandom);
        ref_mem[20] = wd;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd20; cmd_wdata = wd;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (cmd_ready !== 1'b1 && n < 100);
        acc1 = ncyc;
        @(posedge clk); #1;
        cmd_write = 1'b0; cmd_addr = 5'd20; cmd_wdata = 8'($urandom);
        rb = rsp_cnt;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (cmd_ready !== 1'b1 && n < 60);
        acc2 = ncyc;
        n_cmp++;
        if (acc2 - acc1 != 21 || rsp_cnt - rb != 1) begin
            n_mis++;
            $display("FAIL b2b_spacing: spacing=%0d responses=%0d required 21 and 1", acc2 - acc1, rsp_cnt - rb);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (rsp_valid !== 1'b1 && n < 60);
        rd = rsp_rdata;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rd !== wd) begin
            n_mis++;
            $display("FAIL b2b_readback: rsp_valid=%b rdata=%h required 1 and %h", rsp_valid, rd, wd);
        end
    endtask

    task automatic test_random();
        logic [7:0] rd, wd, exp_rd; logic wr; logic [4:0] addr; logic [12:0] exp_fr; int lat, acc;
        for (int i = 0; i < 12; i++) begin
            wr = 1'($urandom_range(0, 1));
            addr = 5'($urandom_range(0, 31));
            wd = 8'($urandom);
            exp_fr = wr ? 13'(int'(addr) * 256 + int'(wd)) : 13'(addr);
            exp_rd = wr ? 8'h00 : ref_mem[addr];
            if (wr) ref_mem[addr] = wd;
            do_cmd("rand", wr, addr, wd, rd, lat, acc);
            n_cmp++;
            if (rd !== exp_rd || frame_q.size() == 0 || frame_q[$] !== {wr, exp_fr}) begin
                n_mis++;
                $display("FAIL rand[%0d]: rdata=%h frame=%h required %h and %h", i, rd,
                         frame_q.size() ? frame_q[$] : 14'h0, exp_rd, {wr, exp_fr});
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] rd; int n, lat, acc, rb;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h0A; cmd_wdata = 8'h00;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (cmd_ready !== 1'b1 && n < 100);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (strobe !== 1'b1 && n < 40);
        repeat (7) @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1 || strobe !== 1'b0) begin
            n_mis++;
            $display("FAIL midrst_pre: busy=%b strobe=%b required 1 and 0 at slot 6", busy, strobe);
        end
        rb = rsp_cnt;
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({strobe, wr_en, din, cmd_ready, rsp_valid, busy, rsp_rdata} !== {6'b000100, 8'h00}) begin
            n_mis++;
            $display("FAIL midrst_async: {strobe,wr_en,din,ready,rsp_valid,busy,rdata}=%b required %b",
                     {strobe, wr_en, din, cmd_ready, rsp_valid, busy, rsp_rdata}, {6'b000100, 8'h00});
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        n_cmp++;
        if (rsp_cnt != rb) begin n_mis++; $display("FAIL midrst_no_rsp: responses=%0d required 0", rsp_cnt - rb); end
        sl_mem[3] = 8'h99; ref_mem[3] = 8'h99;
        do_cmd("midrst_read", 1'b0, 5'h03, 8'h00, rd, lat, acc);
        n_cmp++;
        if (rd !== 8'h99 || frame_q.size() == 0 || frame_q[$] !== 14'h0003) begin
            n_mis++;
            $display("FAIL midrst_recover: rdata=%h frame=%h required 99 and 0003", rd,
                     frame_q.size() ? frame_q[$] : 14'h0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            sl_mem[i]  = 8'($urandom);
            ref_mem[i] = sl_mem[i];
        end
        test_reset();
        test_write();
        test_read();
        test_readback_all();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
